// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: inA - inB - borrowIn, one bit per clock,
// LSB first, through a single full-subtractor cell with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrowOut
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] dSh_q, dSh_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             bw_q, bw_d;
    logic             borrowOut_q, borrowOut_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             aBit, bBit, diffBit, borrowNext, accept;
    logic [WIDTH-1:0] dShifted;

    // The full-subtractor cell; the new difference bit enters d_sh at the MSB so
    // that after WIDTH shifts bit 0 of the result lands at d_sh[0].
    assign aBit       = aSh_q[0];
    assign bBit       = bSh_q[0];
    assign diffBit    = aBit ^ bBit ^ bw_q;
    assign borrowNext = (~aBit & bBit) | (~aBit & bw_q) | (bBit & bw_q);
    assign dShifted   = (dSh_q >> 1) | (WIDTH'(diffBit) << (WIDTH - 1));
    assign accept     = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d     = state_q;
        aSh_d       = aSh_q;
        bSh_d       = bSh_q;
        dSh_d       = dSh_q;
        bw_d        = bw_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        borrowOut_d = borrowOut_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d = aSh_q >> 1;
                bSh_d = bSh_q >> 1;
                dSh_d = dShifted;
                bw_d  = borrowNext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    out_d       = dShifted;
                    borrowOut_d = borrowNext;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            aSh_d = inA;
            bSh_d = inB;
            bw_d  = borrowIn;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            aSh_q       <= '0;
            bSh_q       <= '0;
            dSh_q       <= '0;
            bw_q        <= 1'b0;
            cnt_q       <= '0;
            out_q       <= '0;
            borrowOut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            aSh_q       <= aSh_d;
            bSh_q       <= bSh_d;
            dSh_q       <= dSh_d;
            bw_q        <= bw_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            borrowOut_q <= borrowOut_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out       = out_q;
    assign borrowOut = borrowOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=1, 8 and 32: directed vector
// table, multi-cycle corner sequences and randomized operands against an arithmetic model.
module tb_serial_subtractor;

    logic clock = 1'b0;
    logic reset;

    logic        start1, bin1, busy1, done1, bo1;
    logic [0:0]  a1, b1, out1;
    logic        start8, bin8, busy8, done8, bo8;
    logic [7:0]  a8, b8, out8;
    logic        start32, bin32, busy32, done32, bo32;
    logic [31:0] a32, b32, out32;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] expOut;
        logic       expBo;
    } vec_t;

    vec_t vecs[5];

    always #5 clock = ~clock;

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .inA(a1), .inB(b1),
        .borrowIn(bin1), .busy(busy1), .done(done1), .out(out1), .borrowOut(bo1)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .inA(a8), .inB(b8),
        .borrowIn(bin8), .busy(busy8), .done(done8), .out(out8), .borrowOut(bo8)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .inA(a32), .inB(b32),
        .borrowIn(bin32), .busy(busy32), .done(done32), .out(out32), .borrowOut(bo32)
    );

    function automatic int widthOf(input int sel);
        case (sel)
            0:       return 1;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic getDone(input int sel);
        case (sel)
            0:       return done1;
            1:       return done8;
            default: return done32;
        endcase
    endfunction

    function automatic logic getBusy(input int sel);
        case (sel)
            0:       return busy1;
            1:       return busy8;
            default: return busy32;
        endcase
    endfunction

    function automatic logic getBo(input int sel);
        case (sel)
            0:       return bo1;
            1:       return bo8;
            default: return bo32;
        endcase
    endfunction

    function automatic logic [31:0] getOut(input int sel);
        case (sel)
            0:       return {31'b0, out1};
            1:       return {24'b0, out8};
            default: return out32;
        endcase
    endfunction

    // Reference: plain signed arithmetic on the unsigned operands.
    function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic bin, output logic [31:0] d, output logic bo);
        longint diff;
        longint mask;
        mask = (longint'(1) << w) - 1;
        diff = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'({63'b0, bin});
        d    = 32'(diff & mask);
        bo   = (diff < 0);
    endfunction

    task automatic driveInputs(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input logic bin, input logic st);
        case (sel)
            0:       begin a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; start1 = st; end
            1:       begin a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = st; end
            default: begin a32 = a; b32 = b; bin32 = bin; start32 = st; end
        endcase
    endtask

    task automatic setStart(input int sel, input logic st);
        case (sel)
            0:       start1 = st;
            1:       start8 = st;
            default: start32 = st;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full operation: pulse start, wait (bounded) for done, then check the
    // result, the latency, the busy span and that done drops after one cycle.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin, input logic [31:0] expOut,
                                 input logic expBo, input string tag);
        int lat;
        int busyCnt;
        int w;
        w = widthOf(sel);
        @(negedge clock);
        driveInputs(sel, a, b, bin, 1'b1);
        @(negedge clock);
        setStart(sel, 1'b0);
        lat     = 1;
        busyCnt = 0;
        while (!getDone(sel) && lat < 200) begin
            if (getBusy(sel)) busyCnt++;
            @(negedge clock);
            lat++;
        end
        checkOutput({tag, ".out"}, 64'(getOut(sel)), 64'(expOut));
        checkOutput({tag, ".borrow"}, 64'(getBo(sel)), 64'(expBo));
        checkOutput({tag, ".latency"}, 64'(lat), 64'(w + 1));
        checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(w));
        @(negedge clock);
        checkOutput({tag, ".donePulse"}, 64'(getDone(sel)), 64'd0);
    endtask

    initial begin
        int         doneCnt;
        int         firstLat;
        int         doneLat[2];
        logic [7:0] res[2];
        logic       resBo[2];
        logic [31:0] ra, rb, rd;
        logic        rbin, rbo;
        longint      mask;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};

        reset = 1'b1;
        for (int s = 0; s < 3; s++) driveInputs(s, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("reset.w%0d.busy", widthOf(s)), 64'(getBusy(s)), 64'd0);
            checkOutput($sformatf("reset.w%0d.done", widthOf(s)), 64'(getDone(s)), 64'd0);
            checkOutput($sformatf("reset.w%0d.out", widthOf(s)), 64'(getOut(s)), 64'd0);
            checkOutput($sformatf("reset.w%0d.borrow", widthOf(s)), 64'(getBo(s)), 64'd0);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].bin,
                          {24'b0, vecs[i].expOut}, vecs[i].expBo, $sformatf("table%0d", i));
        end

        // start pulsed mid-RUN with new operands must neither disturb nor queue.
        @(negedge clock);
        driveInputs(1, 32'h05, 32'h03, 1'b0, 1'b1);
        @(negedge clock);
        start8   = 1'b0;
        doneCnt  = 0;
        firstLat = 0;
        for (int c = 1; c <= 24; c++) begin
            if (done8) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    firstLat = c;
                    res[0]   = out8;
                    resBo[0] = bo8;
                end
            end
            if (c == 3) driveInputs(1, 32'hAA, 32'h11, 1'b1, 1'b1);
            if (c == 4) driveInputs(1, 32'h33, 32'h44, 1'b1, 1'b0);
            @(negedge clock);
        end
        checkOutput("ignoreStart.doneCount", 64'(doneCnt), 64'd1);
        checkOutput("ignoreStart.latency", 64'(firstLat), 64'd9);
        checkOutput("ignoreStart.out", 64'(res[0]), 64'h02);
        checkOutput("ignoreStart.borrow", 64'(resBo[0]), 64'd0);
        checkOutput("ignoreStart.idleBusy", 64'(busy8), 64'd0);
        checkOutput("ignoreStart.idleDone", 64'(done8), 64'd0);

        // Reset in the middle of RUN discards the partial result.
        @(negedge clock);
        driveInputs(1, 32'h10, 32'h01, 1'b0, 1'b1);
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midReset.busy", 64'(busy8), 64'd0);
        checkOutput("midReset.done", 64'(done8), 64'd0);
        checkOutput("midReset.out", 64'(out8), 64'h00);
        checkOutput("midReset.borrow", 64'(bo8), 64'd0);
        doneCnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done8) doneCnt++;
            @(negedge clock);
        end
        checkOutput("midReset.noDone", 64'(doneCnt), 64'd0);
        applyStimulus(1, 32'h10, 32'h01, 1'b0, 32'h0F, 1'b0, "afterReset");

        // start held high: second operation accepted straight out of DONE.
        @(negedge clock);
        driveInputs(1, 32'h09, 32'h04, 1'b0, 1'b1);
        doneCnt = 0;
        for (int c = 0; c <= 30; c++) begin
            if (done8) begin
                if (doneCnt < 2) begin
                    doneLat[doneCnt] = c;
                    res[doneCnt]     = out8;
                    resBo[doneCnt]   = bo8;
                end
                doneCnt++;
            end
            if (c == 1) driveInputs(1, 32'h04, 32'h09, 1'b0, 1'b1);
            if (c == 10) start8 = 1'b0;
            @(negedge clock);
        end
        checkOutput("backToBack.doneCount", 64'(doneCnt), 64'd2);
        checkOutput("backToBack.firstAt", 64'(doneLat[0]), 64'd9);
        checkOutput("backToBack.gap", 64'(doneLat[1] - doneLat[0]), 64'd9);
        checkOutput("backToBack.out0", 64'(res[0]), 64'h05);
        checkOutput("backToBack.borrow0", 64'(resBo[0]), 64'd0);
        checkOutput("backToBack.out1", 64'(res[1]), 64'hFB);
        checkOutput("backToBack.borrow1", 64'(resBo[1]), 64'd1);

        for (int s = 0; s < 3; s++) begin
            mask = (longint'(1) << widthOf(s)) - 1;
            for (int k = 0; k < 20; k++) begin
                ra   = $urandom & 32'(mask);
                rb   = $urandom & 32'(mask);
                rbin = 1'($urandom_range(0, 1));
                if (k == 0) begin
                    ra = 32'(mask); rb = 32'(mask); rbin = 1'b1;
                end
                refModel(widthOf(s), ra, rb, rbin, rd, rbo);
                applyStimulus(s, ra, rb, rbin, rd, rbo,
                              $sformatf("rand.w%0d.%0d", widthOf(s), k));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
